// File: rtl/ioport_watch_pkg.sv
// Shared constants for the ioport_watch I/O-write snooper: FSM encoding, 8255 BSR
// field positions and per-channel slice macros for the packed channel parameters.
`ifndef IOPORT_WATCH_PKG_SV
`define IOPORT_WATCH_PKG_SV

`define IOPORT_WATCH_ADDR(p, i) p[(i)*8 +: 8]
`define IOPORT_WATCH_BIT(p, i)  p[(i)*3 +: 3]
`define IOPORT_WATCH_BSR(p, i)  p[(i)]

package ioport_watch_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ARMED = 1'b1;

    // 8255 bit-set/reset control word: D7=0 selects BSR, D3..D1 bit index, D0 value
    localparam int unsigned BSR_MODE_BIT = 7;
    localparam int unsigned BSR_SEL_HI   = 3;
    localparam int unsigned BSR_SEL_LO   = 1;
    localparam int unsigned BSR_VAL_BIT  = 0;

endpackage

`endif

// File: rtl/ioport_watch_if.sv
// Bus bundle between the host-side snoop inputs and the ioport_watch flag/window outputs.
interface ioport_watch_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 4
);
    logic [7:0]       shavv;
    logic [7:0]       data;
    logic             wr_stb;
    logic             arm;
    logic             disarm;
    logic [NCH-1:0]   ch_value;
    logic [NCH-1:0]   ch_stb;
    logic             window_en;
    logic [CNT_W-1:0] edge_cnt;
    logic             done;

    modport master (
        output shavv, data, wr_stb, arm, disarm,
        input  ch_value, ch_stb, window_en, edge_cnt, done
    );

    modport slave (
        input  shavv, data, wr_stb, arm, disarm,
        output ch_value, ch_stb, window_en, edge_cnt, done
    );
endinterface

// File: rtl/ioport_watch_decode.sv
// One watched flag: address match, direct-bit or BSR new-value decode, and the
// registered flag value plus one-cycle write pulse.
module ioport_watch_decode
    import ioport_watch_pkg::*;
#(
    parameter logic [7:0] ADDR = 8'h00,
    parameter logic [2:0] BIT  = 3'd0,
    parameter logic       BSR  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] shavv,
    input  logic [7:0] data,
    input  logic       wr_stb,
    output logic       value,
    output logic       stb
);

    logic [7:0] mask;
    logic       hit;
    logic       bsr_upd;
    logic       upd;
    logic       nxt;

    always_comb begin
        mask    = 8'(1) << BIT;
        hit     = wr_stb && (shavv == ADDR);
        // Control words and other bit indices leave a BSR flag untouched
        bsr_upd = hit && !data[BSR_MODE_BIT] && (data[BSR_SEL_HI:BSR_SEL_LO] == BIT);
        upd     = BSR ? bsr_upd : hit;
        nxt     = BSR ? data[BSR_VAL_BIT] : |(data & mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 1'b0;
            stb   <= 1'b0;
        end else begin
            stb <= upd;
            if (upd) value <= nxt;
        end
    end

endmodule

// File: rtl/ioport_watch.sv
// Vector-06c I/O-write snooper with an arm/count/close event window.
// Define IOPORT_WATCH_TIMEOUT_EN to add a TIMEOUT-cycle window timer.
module ioport_watch
    import ioport_watch_pkg::*;
#(
    parameter int unsigned         NCH      = 2,
    parameter logic [NCH*8-1:0]    CH_ADDR  = {8'h00, 8'h01},
    parameter logic [NCH*3-1:0]    CH_BIT   = {3'd3, 3'd3},
    parameter logic [NCH-1:0]      CH_BSR   = 2'b01,
    parameter int unsigned         WATCH_CH = 0,
    parameter int unsigned         THRESH   = 4,
    parameter int unsigned         CNT_W    = 4,
    parameter logic [23:0]         TIMEOUT  = 24'd2400000
) (
    input  logic          clk,
    input  logic          reset,
    ioport_watch_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = (THRESH != 0) ? CNT_W'(THRESH) : {CNT_W{1'b1}};

    logic [NCH-1:0]   value;
    logic [NCH-1:0]   stb;
    logic             watch_q;
    logic             arm_r;
    logic             state;
    logic             done_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             fall;
    logic             arm_rise;
    logic             thresh_hit;
`ifdef IOPORT_WATCH_TIMEOUT_EN
    logic [23:0]      timer;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ioport_watch_decode #(
            .ADDR (`IOPORT_WATCH_ADDR(CH_ADDR, i)),
            .BIT  (`IOPORT_WATCH_BIT(CH_BIT, i)),
            .BSR  (`IOPORT_WATCH_BSR(CH_BSR, i))
        ) u_dec (
            .clk    (clk),
            .reset  (reset),
            .shavv  (bus.shavv),
            .data   (bus.data),
            .wr_stb (bus.wr_stb),
            .value  (value[i]),
            .stb    (stb[i])
        );
    end

    always_comb begin
        fall       = watch_q & ~value[WATCH_CH];
        arm_rise   = bus.arm & ~arm_r;
        cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        thresh_hit = (THRESH != 0) && fall && (cnt_inc == CNT_W'(THRESH));
    end

    // Window FSM; priority disarm > arm_rise > threshold > timeout > count
    always_ff @(posedge clk) begin
        if (reset) begin
            watch_q <= 1'b0;
            arm_r   <= 1'b0;
            state   <= ST_IDLE;
            cnt     <= '0;
            done_r  <= 1'b0;
`ifdef IOPORT_WATCH_TIMEOUT_EN
            timer   <= '0;
`endif
        end else begin
            watch_q <= value[WATCH_CH];
            arm_r   <= bus.arm;
            done_r  <= 1'b0;
            if (bus.disarm) begin
                state <= ST_IDLE;
            end else if (arm_rise) begin
                state <= ST_ARMED;
                cnt   <= '0;
`ifdef IOPORT_WATCH_TIMEOUT_EN
                timer <= '0;
`endif
            end else if (state == ST_ARMED) begin
                if (fall) cnt <= cnt_inc;
                if (thresh_hit) begin
                    state  <= ST_IDLE;
                    done_r <= 1'b1;
                end
`ifdef IOPORT_WATCH_TIMEOUT_EN
                else if (timer == TIMEOUT - 24'd1) begin
                    state  <= ST_IDLE;
                    done_r <= 1'b1;
                end else begin
                    timer <= timer + 24'd1;
                end
`endif
            end
        end
    end

`ifndef IOPORT_WATCH_TIMEOUT_EN
    if (TIMEOUT == 24'd0) begin : g_timeout_ignored
    end
`endif

    assign bus.ch_value  = value;
    assign bus.ch_stb    = stb;
    assign bus.window_en = state;
    assign bus.edge_cnt  = cnt;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_ioport_watch.sv
// Directed bench for ioport_watch: ch0 is a BSR flag at 8'h00 bit 3 (watched),
// ch1 a direct flag at 8'h01 bit 3; THRESH=4, TIMEOUT=16.
module tb_ioport_watch;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ioport_watch_if #(.NCH(2), .CNT_W(4)) bus ();

    ioport_watch #(
        .NCH      (2),
        .CH_ADDR  (16'h0100),
        .CH_BIT   ({3'd3, 3'd3}),
        .CH_BSR   (2'b01),
        .WATCH_CH (0),
        .THRESH   (4),
        .CNT_W    (4),
        .TIMEOUT  (24'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        bus.shavv  = a;
        bus.data   = d;
        bus.wr_stb = 1'b1;
        tick();
        bus.wr_stb = 1'b0;
    endtask

    // BSR set then clear of ch0: produces one falling edge on the watched flag
    task automatic toggle();
        io_wr(8'h00, 8'h07);
        io_wr(8'h00, 8'h06);
    endtask

    initial begin
        reset      = 1'b1;
        bus.shavv  = 8'h00;
        bus.data   = 8'h00;
        bus.wr_stb = 1'b0;
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        tick();
        tick();
        chk("rst_value", 32'(bus.ch_value), 32'h0);
        chk("rst_stb",   32'(bus.ch_stb),   32'h0);
        chk("rst_win",   32'(bus.window_en), 32'h0);
        chk("rst_cnt",   32'(bus.edge_cnt), 32'h0);
        chk("rst_done",  32'(bus.done),     32'h0);
        reset = 1'b0;
        tick();

        // Direct-bit channel
        io_wr(8'h01, 8'h08);
        chk("dir_set_value", 32'(bus.ch_value), 32'h2);
        chk("dir_set_stb",   32'(bus.ch_stb),   32'h2);
        tick();
        chk("dir_stb_clear", 32'(bus.ch_stb), 32'h0);
        io_wr(8'h01, 8'h00);
        chk("dir_clr_value", 32'(bus.ch_value), 32'h0);

        // BSR channel
        io_wr(8'h00, 8'h07);
        chk("bsr_set",   32'(bus.ch_value), 32'h1);
        chk("bsr_set_stb", 32'(bus.ch_stb), 32'h1);
        io_wr(8'h00, 8'h06);
        chk("bsr_clr",   32'(bus.ch_value), 32'h0);
        io_wr(8'h00, 8'h07);
        io_wr(8'h00, 8'h05);
        chk("bsr_other_bit", 32'(bus.ch_value), 32'h1);
        chk("bsr_other_stb", 32'(bus.ch_stb),   32'h0);
        io_wr(8'h00, 8'h86);
        chk("bsr_ctrl_word", 32'(bus.ch_value), 32'h1);
        chk("bsr_ctrl_stb",  32'(bus.ch_stb),   32'h0);
        io_wr(8'h00, 8'h06);
        tick();
        chk("idle_edge_ignored", 32'(bus.edge_cnt), 32'h0);

        // Window closes on the 4th falling edge
        bus.arm = 1'b1;
        tick();
        chk("arm_win", 32'(bus.window_en), 32'h1);
        chk("arm_cnt", 32'(bus.edge_cnt),  32'h0);
        for (int k = 1; k <= 4; k++) begin
            toggle();
            tick();
            chk("win_cnt",  32'(bus.edge_cnt),  32'(k));
            chk("win_en",   32'(bus.window_en), (k < 4) ? 32'h1 : 32'h0);
            chk("win_done", 32'(bus.done),      (k == 4) ? 32'h1 : 32'h0);
        end
        tick();
        chk("done_once", 32'(bus.done),     32'h0);
        chk("cnt_hold",  32'(bus.edge_cnt), 32'h4);
        toggle();
        tick();
        chk("fifth_edge_cnt",  32'(bus.edge_cnt), 32'h4);
        chk("fifth_edge_done", 32'(bus.done),     32'h0);

        // Re-arm mid-window, then disarm
        bus.arm = 1'b0;
        tick();
        bus.arm = 1'b1;
        tick();
        toggle();
        tick();
        toggle();
        tick();
        chk("rearm_pre_cnt", 32'(bus.edge_cnt), 32'h2);
        bus.arm = 1'b0;
        tick();
        bus.arm = 1'b1;
        tick();
        chk("rearm_cnt",  32'(bus.edge_cnt),  32'h0);
        chk("rearm_win",  32'(bus.window_en), 32'h1);
        chk("rearm_done", 32'(bus.done),      32'h0);
        bus.disarm = 1'b1;
        tick();
        chk("disarm_win",  32'(bus.window_en), 32'h0);
        chk("disarm_done", 32'(bus.done),      32'h0);
        bus.arm = 1'b0;
        tick();
        bus.arm = 1'b1;
        tick();
        chk("disarm_blocks_arm", 32'(bus.window_en), 32'h0);
        bus.disarm = 1'b0;
        bus.arm    = 1'b0;
        tick();

        // arm_rise coincides with the 4th fall
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            toggle();
            tick();
        end
        chk("sim_pre_cnt", 32'(bus.edge_cnt), 32'h3);
        toggle();
        bus.arm = 1'b1;
        tick();
        chk("sim_cnt",  32'(bus.edge_cnt),  32'h0);
        chk("sim_win",  32'(bus.window_en), 32'h1);
        chk("sim_done", 32'(bus.done),      32'h0);

        // Reset mid-window
        io_wr(8'h00, 8'h07);
        chk("pre_rst_value", 32'(bus.ch_value), 32'h1);
        reset   = 1'b1;
        bus.arm = 1'b0;
        tick();
        chk("mid_rst_value", 32'(bus.ch_value),  32'h0);
        chk("mid_rst_win",   32'(bus.window_en), 32'h0);
        chk("mid_rst_cnt",   32'(bus.edge_cnt),  32'h0);
        chk("mid_rst_done",  32'(bus.done),      32'h0);
        reset = 1'b0;
        tick();

        // Window with no edges: timeout closes it when enabled
        bus.arm = 1'b1;
        tick();
        repeat (15) tick();
        chk("to_open_15",  32'(bus.window_en), 32'h1);
        chk("to_nodone_15", 32'(bus.done),     32'h0);
        tick();
`ifdef IOPORT_WATCH_TIMEOUT_EN
        chk("to_close_win",  32'(bus.window_en), 32'h0);
        chk("to_close_done", 32'(bus.done),      32'h1);
        tick();
        chk("to_done_once",  32'(bus.done),      32'h0);
        chk("to_stays_idle", 32'(bus.window_en), 32'h0);
`else
        chk("no_to_win",  32'(bus.window_en), 32'h1);
        chk("no_to_done", 32'(bus.done),      32'h0);
        tick();
        chk("no_to_win_later", 32'(bus.window_en), 32'h1);
`endif
        bus.arm = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
